// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order word requests to imem, prefetch FIFO of {pc, word}, valid/ready to decode.
// Latency: grant at t -> next request at t+1; response at t -> inst_valid at t+1 (registered FIFO write).
// Backpressure: a request is issued only while FIFO occupancy + outstanding < DEPTH, so responses never overflow.
//
// Ports:
//   clk, reset (async active-low, synchronous release)
//   imem_req/imem_addr/imem_gnt        request channel (addr word aligned, held until granted)
//   imem_rvalid/imem_rdata             in-order responses, >= 1 cycle after grant
//   inst_valid/inst_ready/inst_data/inst_pc  decode handshake
//   redirect_valid/redirect_pc         branch/jal/jalr redirect: flush, drop in-flight, restart at target
//   fetch_misaligned                   misaligned redirect target flag
//
// Optional feature: FETCH_ALIGN_CHECK_EN -- a redirect with redirect_pc[1:0] != 0 raises
// fetch_misaligned and halts fetching until the next redirect. Without it the low bits are
// ignored and fetch_misaligned is tied to 0.

module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;

  // Prefetch FIFO holding delivered {pc, word} pairs.
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_word [DEPTH];
  logic [AW-1:0] buf_wr;
  logic [AW-1:0] buf_rd;
  logic [CW-1:0] buf_cnt;

  // PC tags of live (non-discarded) requests, matched to responses in order.
  logic [31:0]   tag_pc [DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic          halted;

  logic          credit_ok;
  logic          gnt_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   target_pc;

  assign target_pc = {redirect_pc[31:2], 2'b00};

  // Outstanding requests reserve FIFO slots, so every response has somewhere to land.
  assign credit_ok = ({1'b0, buf_cnt} + {1'b0, outstanding}) < DEPTH_C;

  // Gating with reset keeps the request low while reset is held yet lets the
  // first request go out in the very first cycle after release.
  assign imem_req  = reset && credit_ok && !halted && !redirect_valid;
  assign imem_addr = fetch_pc;
  assign gnt_fire  = imem_req && imem_gnt;

  assign inst_valid = (buf_cnt != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? buf_word[buf_rd] : '0;
  assign inst_pc    = inst_valid ? buf_pc[buf_rd]   : '0;

  // A response in the redirect cycle belongs to the old stream and is dropped.
  assign push = imem_rvalid && (discard == '0) && !redirect_valid;

  assign outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(imem_rvalid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      buf_wr      <= '0;
      buf_rd      <= '0;
      buf_cnt     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle is stale.
        fetch_pc <= target_pc;
        discard  <= outstanding_nxt;
        buf_wr   <= '0;
        buf_rd   <= '0;
        buf_cnt  <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
      end else begin
        if (gnt_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= tag_wr + AW'(1);
        end
        if (imem_rvalid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          buf_wr <= buf_wr + AW'(1);
          tag_rd <= tag_rd + AW'(1);
        end
        if (pop) begin
          buf_rd <= buf_rd + AW'(1);
        end
        case ({push, pop})
          2'b10:   buf_cnt <= buf_cnt + CW'(1);
          2'b01:   buf_cnt <= buf_cnt - CW'(1);
          default: buf_cnt <= buf_cnt;
        endcase
      end
    end
  end

  // Storage needs no reset: it is only observed through the reset counters.
  always_ff @(posedge clk) begin
    if (gnt_fire) begin
      tag_pc[tag_wr] <= fetch_pc;
    end
    if (push) begin
      buf_pc[buf_wr]   <= tag_pc[tag_rd];
      buf_word[buf_wr] <= imem_rdata;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Every redirect re-evaluates the flag: misaligned target halts, aligned target resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= (redirect_pc[1:0] != 2'b00);
    end
  end
  assign fetch_misaligned = halted;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs   = ^redirect_pc[1:0];
  assign halted           = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the single-cycle RV32I core. It issues in-order word requests to an instruction memory over a request/grant/response handshake and buffers the returned words in a prefetch FIFO. It presents one instruction and its PC at a time to decode through a valid/ready handshake. Redirects from branch, jal and jalr flush the buffer, discard in-flight responses and restart fetching at the target.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16; also caps outstanding requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); deassertion is synchronous to clk.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle (counts only when imem_req=1).
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata  in  32  response instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  32  PC of inst_data.
- redirect_valid  in  1  PC change (branch taken, jal, jalr).
- redirect_pc  in  32  redirect target.
- fetch_misaligned  out  1  misaligned-target flag (see Configuration).

## Operation
- State: fetch_pc (32b), FIFO of {pc, word} with DEPTH entries, outstanding counter (0..DEPTH), discard counter (0..DEPTH), and a halt flag when the feature is compiled in.
- Credit: imem_req=1 iff occupancy + outstanding < DEPTH and not halted and redirect_valid=0. imem_addr=fetch_pc.
- On imem_req&&imem_gnt: the pc is queued in a pc-tag queue, outstanding+1, and fetch_pc+=4 (wraps modulo 2^32).
- On imem_rvalid: outstanding-1. If discard>0, the word is dropped and discard-1. Otherwise {tag pc, imem_rdata} is pushed.
- Pop occurs on inst_valid&&inst_ready. Push and pop in the same cycle are both allowed, including when the FIFO is full.
- Redirect: fetch_pc<=redirect_pc with bits[1:0] cleared. The FIFO and tag queue are emptied. discard<=outstanding after counting this cycle's grant and response. A response arriving in the redirect cycle is dropped. A pop in the redirect cycle completes normally.
- The stall rule (no requests while redirect_valid=1) guarantees that no grant occurs in the redirect cycle.
- The FIFO never overflows by construction of the credit rule. An imem_rvalid with outstanding=0 is illegal and is not checked.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_misaligned=0, all counters 0.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- Latency: a response in cycle t produces inst_valid in cycle t+1, because FIFO writes are registered. A grant in cycle t allows a new request to the next address in cycle t+1 (pipelined; one grant per cycle maximum).
- Redirect in cycle t: inst_valid=0 in t+1, and imem_req=1 at redirect_pc in t+1 (if credit available).
- Reset asserted mid-operation: all state returns to reset values immediately. Responses still in flight at reset are the environment's responsibility to squash.
- inst_data/inst_pc stay stable while inst_valid=1 and inst_ready=0.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 and halt=1.
  - No requests are issued until the next redirect.
  - The next redirect to an aligned target clears the flag in the following cycle.
- Not defined: redirect_pc[1:0] is silently ignored and fetch_misaligned is tied 0.

## Test plan
- Reset release, imem always grants, rvalid 1 cycle after grant, inst_ready=1: inst_pc sequence is 0,4,8,12 on consecutive cycles, with the first inst_valid in the 3rd cycle after release.
- inst_ready=0 with DEPTH=4: exactly 4 grants occur, then imem_req=0. Raising inst_ready resumes requests after the first pop.
- Two requests outstanding, then redirect_valid with redirect_pc=0x100: both stale responses are dropped. The next inst_pc is 0x100 and data matches mem[0x100].
- Redirect in the same cycle as imem_rvalid and a pop: the popped word is delivered, the response is dropped, and the FIFO is empty next cycle.
- imem_gnt withheld for 5 cycles: imem_addr is held constant and imem_req stays 1. With a redirect meanwhile, imem_addr switches to the target.
- With FETCH_ALIGN_CHECK_EN, a redirect to 0x102 gives fetch_misaligned=1 and imem_req=0. A subsequent redirect to 0x200 clears the flag and fetch resumes at 0x200.
